// File: rtl/qq_chain.sv
// qq_chain: single-cycle quick queue built from one register array of NODES*D slots.
// MODE=0 keeps the slots sorted by key (data[W-1:W-KW]) with the smallest key at slot 0.
// Entries with equal keys stay in arrival order. MODE=1 keeps plain arrival order (FIFO).
// Valid entries always occupy the prefix slot[0..count-1], so the valid bits are count-derived.
// Optional macro QQ_STATS_EN adds drop_cnt (saturating ovf count) and hwm (count high-water mark).
module qq_chain #(
  parameter  int W     = 32,
  parameter  int KW    = 8,
  parameter  int NODES = 2,
  parameter  int D     = 4,
  parameter  int MODE  = 0,
  localparam int CAP   = NODES * D,
  localparam int CW    = $clog2(CAP + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          enq,
  input  logic          deq,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          rdy,
  output logic          ovf,
  output logic          udf
`ifdef QQ_STATS_EN
  ,
  output logic [15:0]   drop_cnt,
  output logic [CW-1:0] hwm
`endif
);

  logic [CAP-1:0][W-1:0] slot, src, nxt;
  logic [CW-1:0]         cnt_s, cnt_n, p;
  logic                  do_deq, do_enq;
  logic [KW-1:0]         knew;

  assign knew   = data_i[W-1:W-KW];
  assign empty  = (count == '0);
  assign full   = (count == CW'(CAP));
  assign rdy    = !full || deq;
  // A deq on a full queue frees the slot the simultaneous enq needs.
  assign do_deq = deq && !empty;
  assign do_enq = enq && (!full || do_deq);
  // Occupancy after the (optional) head removal, then after the (optional) insert.
  assign cnt_s  = do_deq ? count - CW'(1) : count;
  assign cnt_n  = cnt_s + CW'(do_enq);

  // Insert position over the post-dequeue array: count of valid keys <= new key (priority) or tail (FIFO).
  always_comb begin
    p = '0;
    if (MODE == 1) begin
      p = cnt_s;
    end else begin
      for (int i = 0; i < CAP; i++)
        if ((CW'(i) < cnt_s) && (src[i][W-1:W-KW] <= knew)) p = p + CW'(1);
    end
  end

  // Per-slot datapath: optional left shift for deq, then right shift above the insert point.
  for (genvar i = 0; i < CAP; i++) begin : g_slot
    if (i == CAP - 1) begin : g_last
      assign src[i] = do_deq ? '0 : slot[i];
    end else begin : g_mid
      assign src[i] = do_deq ? slot[i+1] : slot[i];
    end
    if (i == 0) begin : g_head
      assign nxt[i] = (do_enq && (p == '0)) ? data_i : src[i];
    end else begin : g_tail
      assign nxt[i] = (!do_enq || (CW'(i) < p)) ? src[i] :
                      (CW'(i) == p)             ? data_i : src[i-1];
    end
  end

  // Slot payloads need no reset: only the count-defined prefix is ever observed.
  always_ff @(posedge clk) begin
    slot <= nxt;
  end

  // Occupancy, registered head and error pulses; flush clears like reset.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      count  <= '0;
      data_o <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      count <= cnt_n;
      if (cnt_n != '0) data_o <= nxt[0];
      ovf <= enq && !do_enq;
      udf <= deq && empty;
    end
  end

`ifdef QQ_STATS_EN
  // Drop counter saturates; hwm trails count by one cycle.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      drop_cnt <= '0;
      hwm      <= '0;
    end else begin
      if (enq && !do_enq && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      if (count > hwm) hwm <= count;
    end
  end
`endif

endmodule

// File: tb/tb_qq_chain.sv
// Directed bench for qq_chain: a priority instance (MODE=0) and a FIFO instance (MODE=1), CAP=8.
module tb_qq_chain;
  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          p_flush = 0, p_enq = 0, p_deq = 0;
  logic [W-1:0]  p_din = '0;
  logic [W-1:0]  p_dout;
  logic [CW-1:0] p_count;
  logic          p_full, p_empty, p_rdy, p_ovf, p_udf;
  logic          f_flush = 0, f_enq = 0, f_deq = 0;
  logic [W-1:0]  f_din = '0;
  logic [W-1:0]  f_dout;
  logic [CW-1:0] f_count;
  logic          f_full, f_empty, f_rdy, f_ovf, f_udf;
`ifdef QQ_STATS_EN
  logic [15:0]   p_drop, f_drop;
  logic [CW-1:0] p_hwm, f_hwm;
`endif

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  qq_chain #(.W(W), .KW(8), .NODES(2), .D(4), .MODE(0)) u_pq (
    .clk(clk), .rst(rst), .flush(p_flush), .enq(p_enq), .deq(p_deq), .data_i(p_din),
    .data_o(p_dout), .count(p_count), .full(p_full), .empty(p_empty), .rdy(p_rdy),
    .ovf(p_ovf), .udf(p_udf)
`ifdef QQ_STATS_EN
    , .drop_cnt(p_drop), .hwm(p_hwm)
`endif
  );

  qq_chain #(.W(W), .KW(8), .NODES(2), .D(4), .MODE(1)) u_ff (
    .clk(clk), .rst(rst), .flush(f_flush), .enq(f_enq), .deq(f_deq), .data_i(f_din),
    .data_o(f_dout), .count(f_count), .full(f_full), .empty(f_empty), .rdy(f_rdy),
    .ovf(f_ovf), .udf(f_udf)
`ifdef QQ_STATS_EN
    , .drop_cnt(f_drop), .hwm(f_hwm)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled 1ns after the edge, inputs change there too.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pq(input logic e, input logic d, input logic [W-1:0] din);
    p_enq = e; p_deq = d; p_din = din;
    cyc();
    p_enq = 0; p_deq = 0;
  endtask

  task automatic fq(input logic e, input logic d, input logic [W-1:0] din);
    f_enq = e; f_deq = d; f_din = din;
    cyc();
    f_enq = 0; f_deq = 0;
  endtask

  initial begin
    // Reset with enq/deq asserted: must have no effect.
    p_enq = 1; p_deq = 1; p_din = 32'h12345678;
    cyc(); cyc();
    p_enq = 0; p_deq = 0;
    rst = 1'b1;
    repeat (3) cyc();
    chk("rst_count", 32'(p_count), 0);
    chk("rst_empty", 32'(p_empty), 1);
    chk("rst_full",  32'(p_full), 0);
    chk("rst_rdy",   32'(p_rdy), 1);
    chk("rst_dout",  p_dout, 0);
    chk("rst_ovf",   32'(p_ovf), 0);
    chk("rst_udf",   32'(p_udf), 0);
    chk("rst_f_count", 32'(f_count), 0);
    chk("rst_f_dout",  f_dout, 0);

    // Priority ordering with a duplicate key.
    pq(1, 0, 32'h30000001);
    chk("pq_head1", p_dout, 32'h30000001);
    pq(1, 0, 32'h10000002);
    chk("pq_head2", p_dout, 32'h10000002);
    pq(1, 0, 32'h20000003);
    pq(1, 0, 32'h1000000B);
    chk("pq_cnt4", 32'(p_count), 4);
    chk("pq_head4", p_dout, 32'h10000002);
    pq(0, 1, '0);
    chk("pq_deq1", p_dout, 32'h1000000B);
    chk("pq_cnt3", 32'(p_count), 3);
    pq(0, 1, '0);
    chk("pq_deq2", p_dout, 32'h20000003);
    pq(0, 1, '0);
    chk("pq_deq3", p_dout, 32'h30000001);
    chk("pq_cnt1", 32'(p_count), 1);
    pq(0, 1, '0);
    chk("pq_cnt0", 32'(p_count), 0);
    chk("pq_empty", 32'(p_empty), 1);
    chk("pq_hold", p_dout, 32'h30000001);

    // enq+deq on empty, then deq on empty.
    pq(1, 1, 32'h00000055);
    chk("ed_udf", 32'(p_udf), 1);
    chk("ed_cnt", 32'(p_count), 1);
    chk("ed_dout", p_dout, 32'h00000055);
    pq(0, 1, '0);
    chk("ed_udf_clr", 32'(p_udf), 0);
    chk("ed_cnt0", 32'(p_count), 0);
    pq(0, 1, '0);
    chk("de_udf", 32'(p_udf), 1);
    chk("de_cnt", 32'(p_count), 0);
    pq(0, 0, '0);
    chk("de_udf_clr", 32'(p_udf), 0);

    // Fill to capacity, overflow, then replace-on-full.
    for (int k = 1; k <= 8; k++) pq(1, 0, {8'(k), 24'(k)});
    chk("fill_cnt",  32'(p_count), 8);
    chk("fill_full", 32'(p_full), 1);
    chk("fill_rdy",  32'(p_rdy), 0);
    chk("fill_head", p_dout, 32'h01000001);
    pq(1, 0, 32'h09000009);
    chk("ovf_pulse", 32'(p_ovf), 1);
    chk("ovf_cnt",   32'(p_count), 8);
`ifdef QQ_STATS_EN
    chk("drop_cnt1", 32'(p_drop), 1);
`endif
    pq(0, 0, '0);
    chk("ovf_clr", 32'(p_ovf), 0);
    p_deq = 1;
    #1 chk("full_rdy_deq", 32'(p_rdy), 1);
    p_deq = 0;
    pq(1, 1, 32'h00000077);
    chk("rep_head", p_dout, 32'h00000077);
    chk("rep_cnt",  32'(p_count), 8);
    chk("rep_ovf",  32'(p_ovf), 0);
    pq(0, 1, '0);
    chk("rep_next", p_dout, 32'h02000002);
    pq(0, 1, '0);
    pq(0, 1, '0);
    chk("five_cnt",  32'(p_count), 5);
    chk("five_head", p_dout, 32'h04000004);

    // Flush wins over a concurrent enq.
    p_flush = 1;
    pq(1, 0, 32'h01010101);
    p_flush = 0;
    chk("fl_cnt",   32'(p_count), 0);
    chk("fl_empty", 32'(p_empty), 1);
    chk("fl_ovf",   32'(p_ovf), 0);
    chk("fl_dout",  p_dout, 0);
`ifdef QQ_STATS_EN
    chk("fl_hwm",  32'(p_hwm), 0);
    chk("fl_drop", 32'(p_drop), 0);
`endif
    pq(1, 0, 32'h50000001);
    pq(1, 0, 32'h40000002);
    pq(1, 0, 32'h60000003);
    chk("ref_cnt",  32'(p_count), 3);
    chk("ref_head", p_dout, 32'h40000002);
    pq(0, 0, '0);
`ifdef QQ_STATS_EN
    chk("hwm3", 32'(p_hwm), 3);
`endif

    // FIFO order with simultaneous enq/deq.
    fq(1, 0, 32'h0000000A);
    fq(1, 0, 32'h0000000B);
    fq(1, 0, 32'h0000000C);
    chk("ff_head", f_dout, 32'h0000000A);
    fq(1, 1, 32'h0000000D);
    chk("ff_after", f_dout, 32'h0000000B);
    chk("ff_cnt3",  32'(f_count), 3);
    fq(0, 1, '0);
    chk("ff_c", f_dout, 32'h0000000C);
    fq(0, 1, '0);
    chk("ff_d", f_dout, 32'h0000000D);
    chk("ff_cnt1", 32'(f_count), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/qq_chain.md
Name: qq_chain

Overview:
- Parametrised successor to the two-node quick-queue top.
- Replaces a fixed pair of nodes with a single sorted register array of NODES*D slots, giving a single-cycle priority queue (min key at head) or a plain FIFO, selected by parameter.
- Adds occupancy count, synchronous flush, overflow/underflow pulses and defined simultaneous enq/deq behaviour.
- Sits between the packet-ingress logic and the scheduler as the team's standard quick queue.

Parameters:
- W, 32: entry width in bits.
- KW, 8: key width; key = data[W-1:W-KW]; 1 <= KW <= W.
- NODES, 2: number of node groups; capacity scales linearly.
- D, 4: slots per node group.
- MODE, 0: 0 = priority (smallest key at head), 1 = FIFO (arrival order).
- CAP (localparam), NODES*D: total slots.
- CW (localparam), $clog2(CAP+1): count width.

Ports:
- clk  in  1  one clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous and active-low.
- flush  in  1  synchronous clear; has priority over enq/deq.
- enq  in  1  enqueue request, sampling data_i.
- deq  in  1  dequeue request, removing the head.
- data_i  in  W  entry to enqueue.
- data_o  out  W  current head entry (slot 0), registered.
- count  out  CW  number of valid entries.
- full  out  1  count == CAP.
- empty  out  1  count == 0.
- rdy  out  1  enqueue will be accepted this cycle: !full || deq.
- ovf  out  1  one-cycle pulse: enq rejected.
- udf  out  1  one-cycle pulse: deq on empty.

Behaviour:
- Storage: CAP slots slot[0..CAP-1] plus valid bits. Valid slots are always a prefix 0..count-1.
- Priority mode ordering: slots are sorted non-decreasing by key. Equal keys keep arrival order; a new entry goes after all existing entries with an equal key.
- Reset (rst==0 at posedge): all valid bits 0, count=0, data_o=0, ovf=0, udf=0. Outputs read empty=1, full=0, rdy=1. Slot contents don't-care.
- Reset mid-operation discards all contents. An enq/deq in the reset cycle has no effect.
- flush (rst==1, flush==1): same state result as reset. enq/deq that cycle are ignored; ovf/udf stay 0.
- Insert position p:
  - priority mode: p = number of valid slots with key <= new key;
  - FIFO mode: p = count.
  - Computed combinationally with CAP parallel comparators.
- enq only, not full: slot[p] <= data_i; slots p..count-1 shift right by one; count+1. Latency 1 cycle; the entry is visible on data_o the next cycle if it became the head.
- deq only, not empty: all slots shift left by one; count-1. data_o shows the new head the next cycle.
- enq and deq, count>=1 (including full): result equals "remove old head, then insert". Position is max(p-1,0) over the shifted array; count unchanged; ovf=0. Full with both asserted is legal.
- enq and deq, empty: deq ignored with udf=1; enq performed; count=1.
- enq, full, no deq: enq dropped, contents unchanged, ovf=1 for one cycle.
- deq, empty, no enq: no change, udf=1 for one cycle.
- data_o holds its last value while empty. Consumers must qualify it with !empty.
- count never wraps: saturates at bounds by construction of the rules above.
- No internal state machine beyond the array. Every operation completes in one cycle; there are no back-to-back restrictions.

Optional Feature:
- Macro QQ_STATS_EN.
- Defined: adds outputs drop_cnt (16 bits, counts ovf pulses, saturating at 16'hFFFF) and hwm (CW bits, high-water mark of count). Both are cleared by reset and by flush; hwm updates the cycle after count rises.
- Not defined: those ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset, then idle 3 cycles -> count=0, empty=1, full=0, rdy=1, data_o=0, ovf=udf=0.
- MODE=0, KW=8: enq keys 0x30,0x10,0x20,0x10(data tag B) on consecutive cycles, then 4 deq -> head sequence 0x10(first), 0x10(B), 0x20, 0x30; count 4→0; empty=1 at end.
- MODE=0, CAP=8: fill with keys 1..8, enq key 9 without deq -> ovf=1 one cycle, count=8. Then enq key 0 with deq same cycle -> key 1 removed, head=0, count=8.
- MODE=1: enq 0xA,0xB,0xC; next cycle enq 0xD with deq -> outputs 0xA, then head 0xB; remaining order B,C,D; count=3.
- Empty queue, enq 0x55 with deq same cycle -> udf=1, count=1, data_o=0x55. deq alone on empty -> udf=1, count stays 0.
- 5 entries, flush with enq asserted -> count=0, empty=1, ovf=0. With QQ_STATS_EN: hwm=0 and drop_cnt=0 after flush; after a 3-entry fill, hwm=3.
